tmr_vote_monitor: RTL and testbench
===================================

// Module: tmr_vote_monitor
// PURPOSE
//   Receive end of a triplicated (TMR) datapath: takes the three lane copies of a WIDTH-bit word,
//   majority-votes them bitwise, and delivers one registered corrected word.
//   Tracks which lanes disagreed, counts per-lane upsets in saturating counters, and flags multi-lane faults.
//   A req/ack snapshot handshake lets slow-control read and clear the counters atomically.
//   Sits where triplicated FSM/register outputs leave the TMR domain.
// PARAMETERS
//   WIDTH  8  data width of each lane copy
//   CNT_W  8  width of each per-lane error counter (saturating)
// PORTS
//   clk       in   1      single clock, all state on posedge
//   rst       in   1      asynchronous, active-high reset
//   inA       in   WIDTH  lane A copy
//   inB       in   WIDTH  lane B copy
//   inC       in   WIDTH  lane C copy
//   in_valid  in   1      inputs qualified this cycle
//   out       out  WIDTH  voted word, registered
//   out_valid out  1      out qualified (in_valid delayed 1 cycle)
//   err_lane  out  3      {C,B,A}: lane disagreed with vote on the word now on out
//   err_multi out  1      >=2 lanes disagreed on the word now on out (corrected, double fault)
//   snap_req  in   1      level request: capture and clear counters
//   snap_ack  out  1      snapshot valid; held until snap_req drops
//   snapA     out  CNT_W  captured lane A count
//   snapB     out  CNT_W  captured lane B count
//   snapC     out  CNT_W  captured lane C count
// BEHAVIOUR
//   - Reset (async, any time): out=0, out_valid=0, err_lane=0, err_multi=0, snap_ack=0,
//     snapA/B/C=0, live counters=0, FSM=IDLE. Handshake in progress is aborted.
//   - Vote: v[i] = (A&B)|(B&C)|(A&C) per bit; registered to out at the posedge after in_valid. Latency 1.
//   - When in_valid=0: out holds its last value; out_valid=0; err_lane=0; err_multi=0; counters unchanged.
//   - err_lane[x] = 1 when lane x differs from v in any bit. err_multi = popcount(err_lane) >= 2.
//     All three outputs are registered together with out.
//   - Counters: each live counter (cntA/B/C) +1 per valid word whose lane flag is set.
//     They saturate at 2**CNT_W-1; no wrap.
//   - Snapshot FSM:
//       IDLE: snap_req=1 -> SNAP.
//       SNAP (1 cycle): snapX <= cntX including this cycle's increment.
//         Live counters <= 0 this same cycle; an error in this cycle goes into the snapshot, not the cleared counter.
//         -> ACK.
//       ACK: snap_ack=1; snapX held stable. snap_req=0 -> IDLE (snap_ack=0 on the following cycle).
//   - Counting continues in every state. snap_req held high in ACK causes no re-capture.
//   - A new capture needs snap_req low for at least 1 cycle after the IDLE return.
// TESTING
//   1. A=B=C=8'hA5 for 4 valid cycles -> out=8'hA5 one cycle later; err_lane=0; counters stay 0.
//   2. A=8'h00, B=C=8'hFF valid -> out=8'hFF, err_lane=3'b001, err_multi=0, cntA=1.
//   3. A=8'h01, B=8'h02, C=8'h00 valid -> out=8'h00, err_lane=3'b011, err_multi=1.
//   4. 300 cycles of lane-C error with CNT_W=8 -> snapC after snapshot = 255 (saturated).
//   5. 5 lane-B errors, then snap_req=1 in the same cycle as a 6th error -> snapB=6, snap_ack=1 two cycles later.
//      Next lane-B error gives live count 1.
//   6. rst pulsed mid-ACK with snapA=3 -> snap_ack=0, snapA=0, out=0 immediately (async);
//      normal voting resumes after release.

Source files
------------

// File: rtl/tmr_vote_monitor.sv
// TMR receive-side voter: bitwise majority vote of three lane copies into one
// registered word, per-lane disagreement flags, saturating per-lane upset
// counters and a req/ack snapshot that captures and clears the counters.
module tmr_vote_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [WIDTH-1:0] inC,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [2:0]       err_lane,
  output logic             err_multi,
  input  logic             snap_req,
  output logic             snap_ack,
  output logic [CNT_W-1:0] snapA,
  output logic [CNT_W-1:0] snapB,
  output logic [CNT_W-1:0] snapC
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]       vote;
  logic [2:0]             lane_err;
  logic                   multi_err;

  logic [WIDTH-1:0]       out_q, out_d;
  logic                   out_valid_q, out_valid_d;
  logic [2:0]             err_lane_q, err_lane_d;
  logic                   err_multi_q, err_multi_d;

  // Lane-indexed counter state: index 0 = A, 1 = B, 2 = C.
  logic [2:0][CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [2:0][CNT_W-1:0]  snap_q, snap_d;

  // Bitwise majority and per-lane disagreement against the voted word.
  assign vote        = (inA & inB) | (inB & inC) | (inA & inC);
  assign lane_err[0] = |(inA ^ vote);
  assign lane_err[1] = |(inB ^ vote);
  assign lane_err[2] = |(inC ^ vote);
  assign multi_err   = (lane_err[0] & lane_err[1]) | (lane_err[1] & lane_err[2]) |
                       (lane_err[0] & lane_err[2]);

  // Per-lane saturating increment; this is also what a capture sees, so an
  // upset in the capture cycle lands in the snapshot.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane_cnt
    assign cnt_inc[gi] = (in_valid && lane_err[gi] && (cnt_q[gi] != {CNT_W{1'b1}}))
                         ? cnt_q[gi] + CNT_W'(1) : cnt_q[gi];
  end

  // Voted word and flags: word holds when idle, flags clear when idle.
  always_comb begin
    out_d       = out_q;
    out_valid_d = in_valid;
    err_lane_d  = 3'b000;
    err_multi_d = 1'b0;
    if (in_valid) begin
      out_d       = vote;
      err_lane_d  = lane_err;
      err_multi_d = multi_err;
    end
  end

  // Snapshot FSM next state plus counter/snapshot next values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    snap_d  = snap_q;
    case (state_q)
      IDLE: if (snap_req) state_d = SNAP;
      SNAP: begin
        snap_d  = cnt_inc;
        cnt_d   = '0;
        state_d = ACK;
      end
      ACK:  if (!snap_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any handshake in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_lane_q  <= 3'b000;
      err_multi_q <= 1'b0;
      cnt_q       <= '0;
      snap_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_lane_q  <= err_lane_d;
      err_multi_q <= err_multi_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign err_lane  = err_lane_q;
  assign err_multi = err_multi_q;
  assign snap_ack  = (state_q == ACK);
  assign snapA     = snap_q[0];
  assign snapB     = snap_q[1];
  assign snapC     = snap_q[2];

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Directed bench for tmr_vote_monitor: voting, lane flags, saturation,
// snapshot handshake timing and asynchronous reset during ACK.
module tb_tmr_vote_monitor;

  logic       clk;
  logic       rst;
  logic [7:0] inA, inB, inC;
  logic       in_valid;
  logic [7:0] out;
  logic       out_valid;
  logic [2:0] err_lane;
  logic       err_multi;
  logic       snap_req;
  logic       snap_ack;
  logic [7:0] snapA, snapB, snapC;

  int checks = 0;
  int errors = 0;

  tmr_vote_monitor #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .inA(inA), .inB(inB), .inC(inC), .in_valid(in_valid),
    .out(out), .out_valid(out_valid), .err_lane(err_lane), .err_multi(err_multi),
    .snap_req(snap_req), .snap_ack(snap_ack),
    .snapA(snapA), .snapB(snapB), .snapC(snapC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic v);
    inA = a; inB = b; inC = c; in_valid = v;
  endtask

  // Full capture with no traffic: SNAP cycle, ACK, release, back to IDLE.
  task automatic do_snap(input string tag, input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec);
    in_valid = 1'b0;
    snap_req = 1'b1;
    step();
    chk({tag, "_ack_snapcyc"}, 32'(snap_ack), 32'd0);
    step();
    chk({tag, "_ack"}, 32'(snap_ack), 32'd1);
    chk({tag, "_snapA"}, 32'(snapA), 32'(ea));
    chk({tag, "_snapB"}, 32'(snapB), 32'(eb));
    chk({tag, "_snapC"}, 32'(snapC), 32'(ec));
    snap_req = 1'b0;
    step();
    chk({tag, "_ack_drop"}, 32'(snap_ack), 32'd0);
  endtask

  initial begin
    rst = 1'b1; snap_req = 1'b0;
    word(8'h00, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err_lane", 32'(err_lane), 32'd0);
    chk("rst_err_multi", 32'(err_multi), 32'd0);
    chk("rst_snap_ack", 32'(snap_ack), 32'd0);
    chk("rst_snapC", 32'(snapC), 32'd0);
    rst = 1'b0;
    step();

    // 1: all lanes agree
    for (int i = 0; i < 4; i++) begin
      word(8'hA5, 8'hA5, 8'hA5, 1'b1);
      step();
      chk("t1_out", 32'(out), 32'hA5);
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_err_lane", 32'(err_lane), 32'd0);
    end
    in_valid = 1'b0;
    step();
    chk("t1_hold_out", 32'(out), 32'hA5);
    chk("t1_idle_valid", 32'(out_valid), 32'd0);
    do_snap("t1", 8'd0, 8'd0, 8'd0);

    // 2: single lane A fault
    word(8'h00, 8'hFF, 8'hFF, 1'b1);
    step();
    chk("t2_out", 32'(out), 32'hFF);
    chk("t2_err_lane", 32'(err_lane), 32'b001);
    chk("t2_err_multi", 32'(err_multi), 32'd0);
    do_snap("t2", 8'd1, 8'd0, 8'd0);

    // 3: A and B both disagree with the vote
    word(8'h01, 8'h02, 8'h00, 1'b1);
    step();
    chk("t3_out", 32'(out), 32'h00);
    chk("t3_err_lane", 32'(err_lane), 32'b011);
    chk("t3_err_multi", 32'(err_multi), 32'd1);
    in_valid = 1'b0;
    step();
    chk("t3_idle_err_lane", 32'(err_lane), 32'd0);
    chk("t3_idle_err_multi", 32'(err_multi), 32'd0);
    do_snap("t3", 8'd1, 8'd1, 8'd0);

    // 4: 300 lane-C errors saturate at 255; errors continue through capture
    for (int i = 0; i < 300; i++) begin
      word(8'h3C, 8'h3C, 8'h3D, 1'b1);
      step();
    end
    chk("t4_out", 32'(out), 32'h3C);
    chk("t4_err_lane", 32'(err_lane), 32'b100);
    snap_req = 1'b1;
    step();
    step();
    chk("t4_ack", 32'(snap_ack), 32'd1);
    chk("t4_snapC", 32'(snapC), 32'd255);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold_ack", 32'(snap_ack), 32'd1);
      chk("t4_hold_snapC", 32'(snapC), 32'd255);
    end
    snap_req = 1'b0; in_valid = 1'b0;
    step();
    chk("t4_ack_drop", 32'(snap_ack), 32'd0);

    // 5: request coincides with the 6th lane-B error; live C holds 3 from above
    for (int i = 0; i < 5; i++) begin
      word(8'h11, 8'h10, 8'h11, 1'b1);
      step();
    end
    word(8'h11, 8'h10, 8'h11, 1'b1);
    snap_req = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t5_ack_1cyc", 32'(snap_ack), 32'd0);
    step();
    chk("t5_ack_2cyc", 32'(snap_ack), 32'd1);
    chk("t5_snapA", 32'(snapA), 32'd0);
    chk("t5_snapB", 32'(snapB), 32'd6);
    chk("t5_snapC", 32'(snapC), 32'd3);
    snap_req = 1'b0;
    step();
    chk("t5_ack_drop", 32'(snap_ack), 32'd0);
    word(8'h11, 8'h10, 8'h11, 1'b1);
    step();
    // capture with a lane-A error inside the SNAP cycle
    in_valid = 1'b0; snap_req = 1'b1;
    step();
    word(8'hF0, 8'h0F, 8'h0F, 1'b1);
    step();
    chk("t5_snapcyc_out", 32'(out), 32'h0F);
    chk("t5_snapcyc_err", 32'(err_lane), 32'b001);
    chk("t5_live_snapA", 32'(snapA), 32'd1);
    chk("t5_live_snapB", 32'(snapB), 32'd1);
    chk("t5_live_snapC", 32'(snapC), 32'd0);
    snap_req = 1'b0; in_valid = 1'b0;
    step();
    do_snap("t5_clr", 8'd0, 8'd0, 8'd0);

    // 6: asynchronous reset while in ACK with snapA=3
    for (int i = 0; i < 3; i++) begin
      word(8'hF0, 8'h0F, 8'h0F, 1'b1);
      step();
    end
    in_valid = 1'b0; snap_req = 1'b1;
    step();
    step();
    chk("t6_ack", 32'(snap_ack), 32'd1);
    chk("t6_snapA", 32'(snapA), 32'd3);
    chk("t6_out_pre", 32'(out), 32'h0F);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ack", 32'(snap_ack), 32'd0);
    chk("t6_rst_snapA", 32'(snapA), 32'd0);
    chk("t6_rst_out", 32'(out), 32'h00);
    #2 rst = 1'b0;
    snap_req = 1'b0;
    word(8'h5A, 8'h5A, 8'h5A, 1'b1);
    step();
    chk("t6_resume_out", 32'(out), 32'h5A);
    chk("t6_resume_valid", 32'(out_valid), 32'd1);
    chk("t6_resume_err", 32'(err_lane), 32'd0);
    do_snap("t6", 8'd0, 8'd0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
